// File: rtl/tilemap_write_arbiter.sv
// Tile-map RAM write-port owner: round-robin arbitration between requesters plus a
// full-map clear sequencer, with writes gated to the display's write window.
module tilemap_write_arbiter #(
   parameter int                NUM_REQ    = 3,
   parameter int                ADDR_W     = 16,
   parameter int                DATA_W     = 16,
   parameter int unsigned       MAP_DEPTH  = 1200,
   parameter logic [DATA_W-1:0] BLANK_TILE = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      write_window,
   input  logic                      clear_start,
   output logic                      clear_busy,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      addr_err,
   output logic                      ram_we,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic [DATA_W-1:0]         ram_din
);

   // state    | meaning
   // ST_ARB   | arbitrating requesters; clear_start accepted here
   // ST_CLEAR | sequencer writing BLANK_TILE to 0..MAP_DEPTH-1, requesters stall

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {ST_ARB, ST_CLEAR} state_t;

   state_t              state, state_nxt;
   logic [PTR_W-1:0]    rr_ptr, rr_ptr_nxt;
   logic [NUM_REQ-1:0]  mask, mask_nxt;
   logic [ADDR_W-1:0]   clear_cnt, clear_cnt_nxt;
   logic                clear_busy_nxt;
   logic [NUM_REQ-1:0]  grant_nxt;
   logic                addr_err_nxt;
   logic                ram_we_nxt;
   logic [ADDR_W-1:0]   ram_addr_nxt;
   logic [DATA_W-1:0]   ram_din_nxt;

   logic                found;
   logic [PTR_W-1:0]    win_idx;
   int                  idx;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_data;
   logic                win_addr_ok;
   logic                clear_accept;
   logic                clear_last;

   assign clear_accept = (state == ST_ARB) && clear_start && !clear_busy;
   assign clear_last   = (clear_cnt == ADDR_W'(MAP_DEPTH - 1));

   // Round-robin search starting at rr_ptr; a requester granted last cycle is masked
   // because its req is still high on the edge where it first sees grant.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      idx     = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = int'(rr_ptr) + off;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!found && req[idx] && !mask[idx]) begin
            found   = 1'b1;
            win_idx = PTR_W'(idx);
         end
      end
   end

   assign win_addr    = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
   assign win_data    = req_data[int'(win_idx)*DATA_W +: DATA_W];
   assign win_addr_ok = (64'(win_addr) < 64'(MAP_DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_ARB;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ARB: begin
            if (clear_accept) begin
               state_nxt = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (write_window && clear_last) begin
               state_nxt = ST_ARB;
            end
         end
         default: state_nxt = ST_ARB;
      endcase
   end

   always_comb begin
      rr_ptr_nxt     = rr_ptr;
      mask_nxt       = '0;
      clear_cnt_nxt  = clear_cnt;
      clear_busy_nxt = 1'b0;
      grant_nxt      = '0;
      addr_err_nxt   = 1'b0;
      ram_we_nxt     = 1'b0;
      ram_addr_nxt   = '0;
      ram_din_nxt    = '0;
      case (state)
         ST_ARB: begin
            clear_cnt_nxt  = '0;
            clear_busy_nxt = clear_accept;
            if (write_window && found) begin
               grant_nxt[win_idx] = 1'b1;
               mask_nxt[win_idx]  = 1'b1;
               ram_addr_nxt       = win_addr;
               ram_din_nxt        = win_data;
               ram_we_nxt         = win_addr_ok;
               addr_err_nxt       = !win_addr_ok;
               rr_ptr_nxt         = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                     : win_idx + PTR_W'(1);
            end
         end
         ST_CLEAR: begin
            // Busy stays up through the first ARB cycle after the final clear write.
            clear_busy_nxt = 1'b1;
            if (write_window) begin
               ram_we_nxt    = 1'b1;
               ram_addr_nxt  = clear_cnt;
               ram_din_nxt   = BLANK_TILE;
               clear_cnt_nxt = clear_last ? '0 : clear_cnt + ADDR_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         mask       <= '0;
         clear_cnt  <= '0;
         clear_busy <= 1'b0;
         grant      <= '0;
         addr_err   <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= '0;
      end else begin
         rr_ptr     <= rr_ptr_nxt;
         mask       <= mask_nxt;
         clear_cnt  <= clear_cnt_nxt;
         clear_busy <= clear_busy_nxt;
         grant      <= grant_nxt;
         addr_err   <= addr_err_nxt;
         ram_we     <= ram_we_nxt;
         ram_addr   <= ram_addr_nxt;
         ram_din    <= ram_din_nxt;
      end
   end

endmodule

// File: tb/tb_tilemap_write_arbiter.sv
// Bench for tilemap_write_arbiter: vector table for arbitration, hand sequences for
// clear, paused clear, ignored clear_start and reset mid-clear.
module tb_tilemap_write_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        write_window;
   logic        clear_start;
   logic        clear_busy;
   logic [2:0]  req;
   logic [47:0] req_addr;
   logic [47:0] req_data;
   logic [2:0]  grant;
   logic        addr_err;
   logic        ram_we;
   logic [15:0] ram_addr;
   logic [15:0] ram_din;

   int n_chk  = 0;
   int n_fail = 0;

   tilemap_write_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .write_window (write_window),
      .clear_start  (clear_start),
      .clear_busy   (clear_busy),
      .req          (req),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .grant        (grant),
      .addr_err     (addr_err),
      .ram_we       (ram_we),
      .ram_addr     (ram_addr),
      .ram_din      (ram_din)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        win;
      logic [2:0]  rq;
      logic [47:0] addr;
      logic [47:0] data;
      logic [2:0]  g;
      logic        we;
      logic [15:0] a;
      logic [15:0] d;
      logic        err;
   } vec_t;

   vec_t vt [18];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Steps the clear sequencer until stop_at writes have been seen, dropping the window
   // for gap_len cycles once gap_at writes are done; pulses clear_start once mid-clear.
   task automatic run_clear(input int gap_at, input int gap_len, input int stop_at);
      int e   = 0;
      int gap = 0;
      int cyc = 0;
      while (e < stop_at && cyc < 3000) begin
         write_window = !(e == gap_at && gap < gap_len);
         clear_start  = (e == 100) && write_window;
         tick();
         cyc++;
         if (write_window) begin
            chk("clr_we", ram_we, 1);
            chk("clr_addr", ram_addr, e);
            chk("clr_din", ram_din, 0);
            e++;
         end else begin
            chk("gap_we", ram_we, 0);
            gap++;
         end
         chk("clr_busy", clear_busy, 1);
         chk("clr_grant", grant, 0);
      end
      clear_start  = 1'b0;
      write_window = 1'b1;
      chk("clr_count", e, stop_at);
   endtask

   initial begin
      vt[0]  = '{1'b1, 3'b001, {16'd0, 16'd0, 16'd137}, {16'h0, 16'h0, 16'h0123}, 3'b001, 1'b1, 16'd137, 16'h0123, 1'b0};
      vt[1]  = '{1'b1, 3'b001, {16'd0, 16'd0, 16'd137}, {16'h0, 16'h0, 16'h0123}, 3'b000, 1'b0, 16'd0, 16'h0, 1'b0};
      vt[2]  = '{1'b1, 3'b001, {16'd0, 16'd0, 16'd137}, {16'h0, 16'h0, 16'h0123}, 3'b001, 1'b1, 16'd137, 16'h0123, 1'b0};
      vt[3]  = '{1'b1, 3'b000, {16'd0, 16'd0, 16'd137}, {16'h0, 16'h0, 16'h0123}, 3'b000, 1'b0, 16'd0, 16'h0, 1'b0};
      vt[4]  = '{1'b1, 3'b111, {16'd30, 16'd20, 16'd10}, {16'hCCCC, 16'hBBBB, 16'hAAAA}, 3'b010, 1'b1, 16'd20, 16'hBBBB, 1'b0};
      vt[5]  = '{1'b1, 3'b111, {16'd30, 16'd20, 16'd10}, {16'hCCCC, 16'hBBBB, 16'hAAAA}, 3'b100, 1'b1, 16'd30, 16'hCCCC, 1'b0};
      vt[6]  = '{1'b1, 3'b111, {16'd30, 16'd20, 16'd10}, {16'hCCCC, 16'hBBBB, 16'hAAAA}, 3'b001, 1'b1, 16'd10, 16'hAAAA, 1'b0};
      vt[7]  = '{1'b1, 3'b111, {16'd30, 16'd20, 16'd10}, {16'hCCCC, 16'hBBBB, 16'hAAAA}, 3'b010, 1'b1, 16'd20, 16'hBBBB, 1'b0};
      vt[8]  = '{1'b1, 3'b111, {16'd30, 16'd20, 16'd10}, {16'hCCCC, 16'hBBBB, 16'hAAAA}, 3'b100, 1'b1, 16'd30, 16'hCCCC, 1'b0};
      vt[9]  = '{1'b0, 3'b010, {16'd0, 16'd500, 16'd0}, {16'h0, 16'h1234, 16'h0}, 3'b000, 1'b0, 16'd0, 16'h0, 1'b0};
      vt[10] = '{1'b0, 3'b010, {16'd0, 16'd500, 16'd0}, {16'h0, 16'h1234, 16'h0}, 3'b000, 1'b0, 16'd0, 16'h0, 1'b0};
      vt[11] = '{1'b1, 3'b010, {16'd0, 16'd500, 16'd0}, {16'h0, 16'h1234, 16'h0}, 3'b010, 1'b1, 16'd500, 16'h1234, 1'b0};
      vt[12] = '{1'b1, 3'b000, {16'd0, 16'd500, 16'd0}, {16'h0, 16'h1234, 16'h0}, 3'b000, 1'b0, 16'd0, 16'h0, 1'b0};
      vt[13] = '{1'b1, 3'b100, {16'd1200, 16'd0, 16'd0}, {16'h5555, 16'h0, 16'h0}, 3'b100, 1'b0, 16'd1200, 16'h5555, 1'b1};
      vt[14] = '{1'b1, 3'b000, {16'd1200, 16'd0, 16'd0}, {16'h5555, 16'h0, 16'h0}, 3'b000, 1'b0, 16'd0, 16'h0, 1'b0};
      vt[15] = '{1'b1, 3'b100, {16'd1199, 16'd0, 16'd0}, {16'h7777, 16'h0, 16'h0}, 3'b100, 1'b1, 16'd1199, 16'h7777, 1'b0};
      vt[16] = '{1'b1, 3'b001, {16'd0, 16'd0, 16'hFFFF}, {16'h0, 16'h0, 16'h0001}, 3'b001, 1'b0, 16'hFFFF, 16'h0001, 1'b1};
      vt[17] = '{1'b1, 3'b000, {16'd0, 16'd0, 16'hFFFF}, {16'h0, 16'h0, 16'h0001}, 3'b000, 1'b0, 16'd0, 16'h0, 1'b0};

      rst_n        = 1'b0;
      write_window = 1'b0;
      clear_start  = 1'b0;
      req          = '0;
      req_addr     = '0;
      req_data     = '0;
      #2;
      chk("rst_we", ram_we, 0);
      chk("rst_grant", grant, 0);
      chk("rst_busy", clear_busy, 0);
      chk("rst_err", addr_err, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_din", ram_din, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         write_window = vt[i].win;
         req          = vt[i].rq;
         req_addr     = vt[i].addr;
         req_data     = vt[i].data;
         tick();
         chk($sformatf("v%0d_grant", i), grant, vt[i].g);
         chk($sformatf("v%0d_we", i), ram_we, vt[i].we);
         chk($sformatf("v%0d_addr", i), ram_addr, vt[i].a);
         chk($sformatf("v%0d_din", i), ram_din, vt[i].d);
         chk($sformatf("v%0d_err", i), addr_err, vt[i].err);
         chk($sformatf("v%0d_busy", i), clear_busy, 0);
      end

      // Full clear with requester 0 waiting; a second clear_start in the tail cycle is ignored.
      write_window = 1'b1;
      req          = '0;
      clear_start  = 1'b1;
      tick();
      clear_start = 1'b0;
      chk("c4_busy_rise", clear_busy, 1);
      chk("c4_we0", ram_we, 0);
      req      = 3'b001;
      req_addr = {16'd0, 16'd0, 16'd42};
      req_data = {16'h0, 16'h0, 16'h4242};
      run_clear(-1, 0, 1200);
      chk("c4_busy_tail", clear_busy, 1);
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      chk("c4_busy_fall", clear_busy, 0);
      chk("c4_post_grant", grant, 3'b001);
      chk("c4_post_we", ram_we, 1);
      chk("c4_post_addr", ram_addr, 42);
      chk("c4_post_din", ram_din, 16'h4242);
      tick();
      chk("c4_masked", grant, 3'b000);
      chk("c4_no_reclear", clear_busy, 0);
      req = '0;

      // Grant on the clear_start edge completes; clear pauses 50 cycles at 600.
      req          = 3'b010;
      req_addr     = {16'd0, 16'd77, 16'd0};
      req_data     = {16'h0, 16'h7070, 16'h0};
      clear_start  = 1'b1;
      tick();
      clear_start = 1'b0;
      req         = '0;
      chk("c5_same_grant", grant, 3'b010);
      chk("c5_same_we", ram_we, 1);
      chk("c5_same_addr", ram_addr, 77);
      chk("c5_busy", clear_busy, 1);
      run_clear(600, 50, 1200);
      tick();
      chk("c5_busy_fall", clear_busy, 0);
      chk("c5_idle_we", ram_we, 0);

      // Reset while the clear is at 300.
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      chk("c6_busy", clear_busy, 1);
      run_clear(-1, 0, 300);
      rst_n = 1'b0;
      #1;
      chk("c6_rst_busy", clear_busy, 0);
      chk("c6_rst_we", ram_we, 0);
      chk("c6_rst_addr", ram_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("c6_after_we", ram_we, 0);
         chk("c6_after_busy", clear_busy, 0);
      end
      req      = 3'b111;
      req_addr = {16'd30, 16'd20, 16'd10};
      req_data = {16'hCCCC, 16'hBBBB, 16'hAAAA};
      tick();
      chk("c6_rr_reset", grant, 3'b001);
      req = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
